// File: rtl/sample_stream_uart_tx_if.sv
// Purpose: AXI-Stream style word handshake between the acquisition monitors and
//          the UART sample transmitter.
// Signals: tdata  - 32-bit sample word (low half carries the value)
//          tvalid - source has a word
//          tready - sink can accept a word
interface sample_stream_uart_tx_if;
    localparam int unsigned DATA_W = 32;

    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/sample_stream_uart_tx.sv
// Purpose: accepts 32-bit sample words and sends tdata[15:0] as unsigned decimal
//          ASCII followed by CR LF over an 8N1 UART.
// Ports:   clk      - system clock
//          reset    - synchronous, active-high reset
//          s_axis   - sample stream sink (tdata/tvalid in, tready out)
//          uart_txd - serial output, idle high, driven from a flop
//          busy     - high from word acceptance until the last stop bit ends
module sample_stream_uart_tx #(
    parameter int unsigned CLK_HZ = 100_000_000,
    parameter int unsigned BAUD   = 115_200
) (
    input  logic                    clk,
    input  logic                    reset,
    sample_stream_uart_tx_if.slave  s_axis,
    output logic                    uart_txd,
    output logic                    busy
);
    localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int unsigned CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BIN_W  = 16;
    localparam int unsigned BCD_W  = 20;
    localparam int unsigned ITER_W = 4;
    localparam int unsigned BIT_W  = 4;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned SHR_W  = 9;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        LOAD    = 2'd2,
        SEND    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [BIN_W-1:0]    bin_q, bin_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d;
    logic [ITER_W-1:0]   iter_q, iter_d;
    logic [IDX_W-1:0]    idx_q, idx_d;      // character slot: 0..4 digits (MSD first), 5 CR, 6 LF
    logic [SHR_W-1:0]    shift_q, shift_d;  // remaining data bits plus stop bit
    logic [BIT_W-1:0]    bit_q, bit_d;      // bit position within the frame, 0 = start
    logic [CNT_W-1:0]    clk_cnt_q, clk_cnt_d;
    logic                txd_q, txd_d;
    logic                tready_q, tready_d;
    logic                busy_q, busy_d;

    logic [BCD_W+BIN_W-1:0] dd_shift;
    logic [7:0]             load_char;

    // Double-dabble correction: every BCD digit >= 5 gets +3 before the shift.
    function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < 5; i++) begin
            if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    // Slot of the most significant non-zero digit; the units slot when the value is 0.
    function automatic logic [IDX_W-1:0] first_slot(input logic [BCD_W-1:0] b);
        logic [IDX_W-1:0] s;
        s = 3'd4;
        for (int i = 3; i >= 0; i--) begin
            if (b[(4-i)*4 +: 4] != 4'd0) s = IDX_W'(i);
        end
        return s;
    endfunction

    assign dd_shift = {dd_adjust(bcd_q), bin_q} << 1;

    // Character for the current slot.
    always_comb begin
        load_char = 8'h0A;
        case (idx_q)
            3'd0:    load_char = 8'h30 + {4'h0, bcd_q[19:16]};
            3'd1:    load_char = 8'h30 + {4'h0, bcd_q[15:12]};
            3'd2:    load_char = 8'h30 + {4'h0, bcd_q[11:8]};
            3'd3:    load_char = 8'h30 + {4'h0, bcd_q[7:4]};
            3'd4:    load_char = 8'h30 + {4'h0, bcd_q[3:0]};
            3'd5:    load_char = 8'h0D;
            default: load_char = 8'h0A;
        endcase
    end

    // Next-state and datapath.
    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        iter_d    = iter_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        bit_d     = bit_q;
        clk_cnt_d = clk_cnt_q;
        txd_d     = txd_q;

        case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (s_axis.tvalid) begin
                    bin_d   = s_axis.tdata[BIN_W-1:0];
                    bcd_d   = '0;
                    iter_d  = '0;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                {bcd_d, bin_d} = dd_shift;
                iter_d         = iter_q + 4'd1;
                if (iter_q == 4'd15) begin
                    idx_d   = first_slot(dd_shift[BCD_W+BIN_W-1:BIN_W]);
                    state_d = LOAD;
                end
            end
            LOAD: begin
                shift_d   = {1'b1, load_char};
                txd_d     = 1'b0;
                bit_d     = '0;
                clk_cnt_d = '0;
                state_d   = SEND;
            end
            SEND: begin
                if (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    clk_cnt_d = '0;
                    if (bit_q == 4'd9) begin
                        // Stop bit finished; line stays high through LOAD or IDLE.
                        if (idx_q == 3'd6) begin
                            state_d = IDLE;
                        end else begin
                            idx_d   = idx_q + 3'd1;
                            state_d = LOAD;
                        end
                    end else begin
                        txd_d   = shift_q[0];
                        shift_d = {1'b0, shift_q[SHR_W-1:1]};
                        bit_d   = bit_q + 4'd1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        tready_d = (state_d == IDLE);
        busy_d   = (state_d != IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            bin_q     <= '0;
            bcd_q     <= '0;
            iter_q    <= '0;
            idx_q     <= '0;
            shift_q   <= '1;
            bit_q     <= '0;
            clk_cnt_q <= '0;
            txd_q     <= 1'b1;
            tready_q  <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            bcd_q     <= bcd_d;
            iter_q    <= iter_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            bit_q     <= bit_d;
            clk_cnt_q <= clk_cnt_d;
            txd_q     <= txd_d;
            tready_q  <= tready_d;
            busy_q    <= busy_d;
        end
    end

    assign s_axis.tready = tready_q;
    assign uart_txd      = txd_q;
    assign busy          = busy_q;
endmodule
